// File: rtl/franken_mem_arbiter.sv
// Fetch/data arbiter in front of one single-ported, pipelined RAM, with tag-routed read data.
// Optional grant/conflict counters are built when FRANKEN_ARB_STATS_EN is defined.
module franken_mem_arbiter #(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef FRANKEN_ARB_STATS_EN
    ,
    output logic [31:0] stat_i_gnt,
    output logic [31:0] stat_d_gnt,
    output logic [31:0] stat_conflict
`endif
);
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;
    localparam logic        OWNER_I    = 1'b0;
    localparam logic        OWNER_D    = 1'b1;

    logic [3:0]         starve_q, starve_d;
    logic [MEM_LAT-1:0] tag_valid_q, tag_valid_d;
    logic [MEM_LAT-1:0] tag_owner_q, tag_owner_d;

    logic contend;
    logic i_win;
    logic d_win;
    logic rd_issue;
    logic tail_valid;
    logic tail_owner;

    // reset (active low) also acts as an output enable for the combinational grant path
    always_comb begin
        contend  = reset & mem_ready & i_req & d_req;
        i_win    = reset & mem_ready & i_req & (~d_req | (starve_q == STARVE_LIM));
        d_win    = reset & mem_ready & d_req & ~i_win;
        rd_issue = i_win | (d_win & ~d_we);
    end

    always_comb begin
        starve_d = starve_q;
        if (i_win) begin
            starve_d = 4'd0;
        end else if (contend && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Stage 0 takes the new tag; owner is don't-care when the valid bit is low
    always_comb begin
        tag_valid_d    = tag_valid_q;
        tag_owner_d    = tag_owner_q;
        tag_valid_d[0] = rd_issue;
        tag_owner_d[0] = d_win ? OWNER_D : OWNER_I;
        for (int k = MEM_LAT - 1; k > 0; k--) begin
            tag_valid_d[k] = tag_valid_q[k-1];
            tag_owner_d[k] = tag_owner_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q    <= 4'd0;
            tag_valid_q <= '0;
            tag_owner_q <= '0;
        end else begin
            starve_q    <= starve_d;
            tag_valid_q <= tag_valid_d;
            tag_owner_q <= tag_owner_d;
        end
    end

    always_comb begin
        tail_valid = tag_valid_q[MEM_LAT-1];
        tail_owner = tag_owner_q[MEM_LAT-1];
    end

    always_comb begin
        i_gnt     = i_win;
        d_gnt     = d_win;
        mem_req   = i_win | d_win;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (i_win) begin
            mem_be   = 4'b1111;
            mem_addr = i_addr & WORD_MASK;
        end else if (d_win) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr & WORD_MASK;
            mem_wdata = d_wdata;
        end
        i_rvalid = reset & tail_valid & (tail_owner == OWNER_I);
        d_rvalid = reset & tail_valid & (tail_owner == OWNER_D);
        i_rdata  = reset ? mem_rdata : 32'd0;
        d_rdata  = reset ? mem_rdata : 32'd0;
    end

`ifdef FRANKEN_ARB_STATS_EN
    logic [31:0] stat_i_q, stat_i_d;
    logic [31:0] stat_d_q, stat_d_d;
    logic [31:0] stat_c_q, stat_c_d;

    always_comb begin
        stat_i_d = stat_i_q + 32'(i_win);
        stat_d_d = stat_d_q + 32'(d_win);
        stat_c_d = stat_c_q + 32'(contend);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_i_q <= 32'd0;
            stat_d_q <= 32'd0;
            stat_c_q <= 32'd0;
        end else begin
            stat_i_q <= stat_i_d;
            stat_d_q <= stat_d_d;
            stat_c_q <= stat_c_d;
        end
    end

    assign stat_i_gnt    = stat_i_q;
    assign stat_d_gnt    = stat_d_q;
    assign stat_conflict = stat_c_q;
`endif

endmodule

// File: tb/tb_franken_mem_arbiter.sv
// Bench for franken_mem_arbiter: directed scenarios then random traffic against a
// queue-based reference model with a behavioural word memory.
`timescale 1ns/1ps
module tb_franken_mem_arbiter;
    localparam int LAT  = 2;
    localparam int SMAX = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_ready, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef FRANKEN_ARB_STATS_EN
    logic [31:0] stat_i_gnt, stat_d_gnt, stat_conflict;
`endif

    always #5 clk = ~clk;

    franken_mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef FRANKEN_ARB_STATS_EN
        , .stat_i_gnt(stat_i_gnt), .stat_d_gnt(stat_d_gnt), .stat_conflict(stat_conflict)
`endif
    );

    typedef struct {
        bit          owner;   // 1 = data side
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t       rq[$];
    logic [31:0] mem_m [int];
    int          starve_m;
    int          cyc;
    int          checks = 0;
    int          errors = 0;
    bit          m_i_gnt, m_d_gnt, m_i_rv, m_d_rv;
    logic [31:0] st_i, st_d, st_c;
    logic        o_i_gnt, o_d_gnt, o_req, o_we, o_i_rv, o_d_rv;
    logic [3:0]  o_be;
    logic [31:0] o_addr;
    bit          i_out, d_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        int k;
        k = int'(a[31:2]);
        if (mem_m.exists(k)) return mem_m[k];
        return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step();
        bit          due_now, iw, dw, cont, rd;
        logic [31:0] ew;
        due_now   = (rq.size() > 0) && (rq[0].due == cyc);
        mem_rdata = due_now ? rq[0].data : $urandom();
        @(negedge clk);
        o_i_gnt = i_gnt; o_d_gnt = d_gnt; o_req = mem_req; o_we = mem_we;
        o_be = mem_be; o_addr = mem_addr; o_i_rv = i_rvalid; o_d_rv = d_rvalid;
`ifdef FRANKEN_ARB_STATS_EN
        check("stat_i", stat_i_gnt, reset ? st_i : 32'd0);
        check("stat_d", stat_d_gnt, reset ? st_d : 32'd0);
        check("stat_c", stat_conflict, reset ? st_c : 32'd0);
`endif
        if (!reset) begin
            check("rst_ctl", {22'd0, i_gnt, d_gnt, mem_req, mem_we, i_rvalid, d_rvalid, mem_be}, 32'd0);
            check("rst_addr", mem_addr, 32'd0);
            check("rst_wdata", mem_wdata, 32'd0);
            check("rst_rdata", i_rdata | d_rdata, 32'd0);
            rq.delete();
            starve_m = 0;
            st_i = 0; st_d = 0; st_c = 0;
            m_i_gnt = 0; m_d_gnt = 0; m_i_rv = 0; m_d_rv = 0;
            $display("cyc %0d reset", cyc);
        end else begin
            cont = mem_ready && i_req && d_req;
            iw   = mem_ready && i_req && (!d_req || starve_m == SMAX);
            dw   = mem_ready && d_req && !iw;
            m_i_gnt = iw;
            m_d_gnt = dw;
            m_i_rv  = due_now && !rq[0].owner;
            m_d_rv  = due_now && rq[0].owner;
            check("i_gnt", 32'(i_gnt), 32'(iw));
            check("d_gnt", 32'(d_gnt), 32'(dw));
            check("mem_req", 32'(mem_req), 32'(iw | dw));
            if (iw) begin
                check("i_mem_addr", mem_addr, i_addr & 32'hFFFF_FFFC);
                check("i_mem_be", 32'(mem_be), 32'hF);
                check("i_mem_we", 32'(mem_we), 32'd0);
                check("i_mem_wdata", mem_wdata, 32'd0);
            end
            if (dw) begin
                check("d_mem_addr", mem_addr, d_addr & 32'hFFFF_FFFC);
                check("d_mem_be", 32'(mem_be), 32'(d_be));
                check("d_mem_we", 32'(mem_we), 32'(d_we));
                check("d_mem_wdata", mem_wdata, d_wdata);
            end
            check("i_rvalid", 32'(i_rvalid), 32'(m_i_rv));
            check("d_rvalid", 32'(d_rvalid), 32'(m_d_rv));
            if (m_i_rv) check("i_rdata", i_rdata, rq[0].data);
            if (m_d_rv) check("d_rdata", d_rdata, rq[0].data);
            if (due_now) void'(rq.pop_front());
            if (iw) starve_m = 0;
            else if (cont && starve_m < SMAX) starve_m++;
            st_i += 32'(iw); st_d += 32'(dw); st_c += 32'(cont);
            rd = iw || (dw && !d_we);
            if (rd) rq.push_back('{owner: dw, data: word_of(iw ? i_addr : d_addr), due: cyc + LAT});
            if (dw && d_we) begin
                ew = word_of(d_addr);
                for (int b = 0; b < 4; b++)
                    if (d_be[b]) ew[8*b +: 8] = d_wdata[8*b +: 8];
                mem_m[int'(d_addr[31:2])] = ew;
            end
            if (iw) $display("cyc %0d I read  addr=%h", cyc, i_addr);
            if (dw) $display("cyc %0d D %s addr=%h be=%b", cyc, d_we ? "store" : "load ", d_addr, d_be);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic set_d(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        d_req = 1'b1; d_we = we; d_addr = a; d_be = be; d_wdata = wd;
    endtask

    task automatic rand_drive();
        if (!reset) reset = 1'b1;
        if (m_i_gnt) begin i_req = 1'b0; i_out = 1'b1; end
        if (m_i_rv) i_out = 1'b0;
        if (m_d_gnt) begin d_req = 1'b0; d_out = !d_we; end
        if (m_d_rv) d_out = 1'b0;
        if (i_req && $urandom_range(0, 15) == 0) i_req = 1'b0;
        else if (!i_req && !i_out && $urandom_range(0, 1) == 1) begin
            i_req = 1'b1; i_addr = 32'($urandom_range(0, 255));
        end
        if (d_req && $urandom_range(0, 15) == 0) d_req = 1'b0;
        else if (!d_req && !d_out && $urandom_range(0, 1) == 1)
            set_d(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                  4'($urandom_range(1, 15)), $urandom());
        mem_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 399) == 0) begin
            reset = 1'b0; i_out = 1'b0; d_out = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] conf_base;
        cyc = 0; starve_m = 0; st_i = 0; st_d = 0; st_c = 0;
        i_out = 0; d_out = 0; conf_base = 0;
        reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'd0;
        i_req = 1'b1; i_addr = 32'h40;
        set_d(1'b0, 32'h80, 4'hF, 32'h1234_5678);
        @(posedge clk);
        #1;
        step(); step();
        idle();
        reset = 1'b1;

        // fetch only
        i_req = 1'b1; i_addr = 32'h100;
        step();
        check("t1_i_gnt", 32'(o_i_gnt), 32'd1);
        check("t1_addr", o_addr, 32'h100);
        check("t1_be", 32'(o_be), 32'hF);
        i_req = 1'b0;
        step(); step();
        check("t1_i_rv", 32'(o_i_rv), 32'd1);

        // contention: D first, responses in issue order
        i_req = 1'b1; i_addr = 32'h100;
        set_d(1'b0, 32'h2000, 4'hF, 32'd0);
        step();
        check("t2_c0_d_gnt", 32'(o_d_gnt), 32'd1);
        d_req = 1'b0;
        step();
        check("t2_c1_i_gnt", 32'(o_i_gnt), 32'd1);
        i_req = 1'b0;
        step();
        check("t2_c2_rv", {30'd0, o_i_rv, o_d_rv}, 32'd1);
        step();
        check("t2_c3_rv", {30'd0, o_i_rv, o_d_rv}, 32'd2);

        // starvation: I wins on the fourth contended cycle
        i_req = 1'b1; i_addr = 32'h300;
        for (int k = 0; k < 5; k++) begin
            set_d(1'b1, 32'h400 + 32'(4 * k), 4'hF, $urandom());
            step();
            check("t3_d_gnt", 32'(o_d_gnt), 32'(k != 3));
            check("t3_i_gnt", 32'(o_i_gnt), 32'(k == 3));
            if (o_i_gnt) i_req = 1'b0;
        end
        idle();
        step(); step(); step();

        // partial store
        set_d(1'b1, 32'h203, 4'b1000, 32'hAB00_0000);
        step();
        check("t4_addr", o_addr, 32'h200);
        check("t4_we", 32'(o_we), 32'd1);
        check("t4_be", 32'(o_be), 32'h8);
        check("t4_d_gnt", 32'(o_d_gnt), 32'd1);
        idle();
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_no_rv", 32'(o_d_rv), 32'd0);
        end

        // memory not ready
`ifdef FRANKEN_ARB_STATS_EN
        conf_base = stat_conflict;
`endif
        i_req = 1'b1; i_addr = 32'h500;
        set_d(1'b0, 32'h600, 4'hF, 32'd0);
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t6_stall", {29'd0, o_i_gnt, o_d_gnt, o_req}, 32'd0);
        end
        mem_ready = 1'b1;
        step();
        check("t6_d_gnt", 32'(o_d_gnt), 32'd1);
`ifdef FRANKEN_ARB_STATS_EN
        check("t6_conflict", stat_conflict, conf_base + 32'd1);
`endif
        d_req = 1'b0;
        step();
        i_req = 1'b0;
        step(); step(); step();

        // reset with two reads in flight
        i_req = 1'b1; i_addr = 32'h700;
        step();
        i_req = 1'b0;
        set_d(1'b0, 32'h800, 4'hF, 32'd0);
        step();
        reset = 1'b0; i_req = 1'b1;
        step();
        reset = 1'b1;
        idle();
        for (int k = 0; k < 4; k++) begin
            step();
            check("t5_no_rv", {30'd0, o_i_rv, o_d_rv}, 32'd0);
        end
        i_req = 1'b1; i_addr = 32'h900;
        step();
        check("t5_new_gnt", 32'(o_i_gnt), 32'd1);
        i_req = 1'b0;
        step(); step();
        check("t5_new_rv", 32'(o_i_rv), 32'd1);

        // random traffic
        idle();
        m_i_gnt = 0; m_d_gnt = 0; m_i_rv = 0; m_d_rv = 0;
        for (int n = 0; n < 3000; n++) begin
            rand_drive();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
